// File: rtl/multi_shift_sequencer.sv
// Splits a rotate request of up to 63 positions into passes of at most 7 through an external
// 8-bit barrel shifter. Optional MULTI_SHIFT_MOD_REDUCE_EN reduces the amount modulo WIDTH on accept.
module multi_shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int SW    = 3,
   parameter int AMT_W = 6,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_dir,
   output logic [WIDTH-1:0] sh_a,
   output logic [SW-1:0]    sh_s,
   output logic             sh_dir,
   input  logic [WIDTH-1:0] sh_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] steps,
   output logic             busy
);

   // state | meaning
   // IDLE  | waiting for a request, in_ready high
   // SHIFT | one shifter pass per cycle until rem reaches zero
   // DONE  | result held on out_data until out_ready
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [SW-1:0]    SMAX      = '1;
   localparam logic [CNT_W-1:0] STEPS_MAX = '1;

   state_t           state;
   logic [WIDTH-1:0] data_reg;
   logic [AMT_W-1:0] rem;
   logic             dir_reg;
   logic [AMT_W-1:0] rem_next;
   logic [AMT_W-1:0] amt_load;

`ifdef MULTI_SHIFT_MOD_REDUCE_EN
   // a rotation by WIDTH is the identity, so only the low SW bits matter
   assign amt_load = in_amt & AMT_W'(SMAX);
`else
   assign amt_load = in_amt;
`endif

   always_comb begin
      sh_s = '0;
      if (state == SHIFT)
         sh_s = (rem > AMT_W'(SMAX)) ? SMAX : rem[SW-1:0];
   end

   assign rem_next  = rem - AMT_W'(sh_s);
   assign sh_a      = data_reg;
   assign sh_dir    = dir_reg;
   assign out_data  = data_reg;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign in_ready  = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         data_reg <= '0;
         rem      <= '0;
         dir_reg  <= 1'b0;
         steps    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_reg <= in_data;
                  rem      <= amt_load;
                  dir_reg  <= in_dir;
                  steps    <= '0;
                  state    <= (amt_load == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               data_reg <= sh_y;
               rem      <= rem_next;
               if (steps != STEPS_MAX)
                  steps <= steps + 1'b1;
               if (rem_next == '0)
                  state <= DONE;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_shift_sequencer.sv
// Directed bench for multi_shift_sequencer with a behavioural rotator standing in for barrel_shifter.
module tb_multi_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [5:0] in_amt;
   logic       in_dir;
   logic [7:0] sh_a;
   logic [2:0] sh_s;
   logic       sh_dir;
   logic [7:0] sh_y;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] steps;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   multi_shift_sequencer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_dir(in_dir),
      .sh_a(sh_a), .sh_s(sh_s), .sh_dir(sh_dir), .sh_y(sh_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .steps(steps), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rot(input logic [7:0] a, input logic [2:0] s, input logic d);
      logic [15:0] w;
      w = {a, a};
      if (d) rot = 8'(w >> s);
      else   rot = 8'((w << s) >> 8);
   endfunction

   assign sh_y = rot(sh_a, sh_s, sh_dir);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // issue a request, collect the sh_s sequence, return edges from accept until out_valid
   task automatic request(input logic [7:0] d, input logic [5:0] a, input logic dr,
                          output int n, output logic [2:0] s0, output logic [2:0] s1,
                          output logic [2:0] s2);
      check("in_ready_before_req", 32'(in_ready), 32'd1);
      in_data  = d;
      in_amt   = a;
      in_dir   = dr;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n  = 0;
      s0 = '0; s1 = '0; s2 = '0;
      while (!out_valid && n < 50) begin
         if (n == 0) s0 = sh_s;
         if (n == 1) s1 = sh_s;
         if (n == 2) s2 = sh_s;
         step();
         n++;
      end
      check("out_valid_reached", 32'(out_valid), 32'd1);
   endtask

   int         n;
   logic [2:0] s0, s1, s2;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_dir    = 1'b0;
      out_ready = 1'b1;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_steps", 32'(steps), 32'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      step();

      // 0x97 rotl 3
      request(8'h97, 6'd3, 1'b0, n, s0, s1, s2);
      check("t1_latency", 32'(n), 32'd1);
      check("t1_sh_s0", 32'(s0), 32'd3);
      check("t1_data", 32'(out_data), 32'hBC);
      check("t1_steps", 32'(steps), 32'd1);
      step();
      check("t1_in_ready_after", 32'(in_ready), 32'd1);
      check("t1_out_valid_after", 32'(out_valid), 32'd0);

      // 0x6B rotr 20
      request(8'h6B, 6'd20, 1'b1, n, s0, s1, s2);
      check("t2_data", 32'(out_data), 32'hB6);
`ifdef MULTI_SHIFT_MOD_REDUCE_EN
      check("t2_latency", 32'(n), 32'd1);
      check("t2_sh_s0", 32'(s0), 32'd4);
      check("t2_steps", 32'(steps), 32'd1);
`else
      check("t2_latency", 32'(n), 32'd3);
      check("t2_sh_s0", 32'(s0), 32'd7);
      check("t2_sh_s1", 32'(s1), 32'd7);
      check("t2_sh_s2", 32'(s2), 32'd6);
      check("t2_steps", 32'(steps), 32'd3);
`endif
      step();

      // amount zero: no shifter pass, DONE right after the accept edge
      request(8'h5A, 6'd0, 1'b1, n, s0, s1, s2);
      check("t3_latency", 32'(n), 32'd0);
      check("t3_sh_s", 32'(sh_s), 32'd0);
      check("t3_data", 32'(out_data), 32'h5A);
      check("t3_steps", 32'(steps), 32'd0);
      step();

      // 0x81 rotl 14 with back-pressure and an ignored request
      out_ready = 1'b0;
      request(8'h81, 6'd14, 1'b0, n, s0, s1, s2);
`ifdef MULTI_SHIFT_MOD_REDUCE_EN
      check("t4_latency", 32'(n), 32'd1);
      check("t4_steps", 32'(steps), 32'd1);
`else
      check("t4_latency", 32'(n), 32'd2);
      check("t4_steps", 32'(steps), 32'd2);
`endif
      in_data  = 8'hC3;
      in_amt   = 6'd5;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_data", 32'(out_data), 32'h60);
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_in_ready", 32'(in_ready), 32'd0);
         step();
      end
`ifdef MULTI_SHIFT_MOD_REDUCE_EN
      check("t4_hold_steps", 32'(steps), 32'd1);
`else
      check("t4_hold_steps", 32'(steps), 32'd2);
`endif
      check("t4_ignored_data", 32'(out_data), 32'h60);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("t4_in_ready_at_hs", 32'(in_ready), 32'd0);
      step();
      check("t4_in_ready_after", 32'(in_ready), 32'd1);
      check("t4_out_valid_after", 32'(out_valid), 32'd0);

      // reset during a long request
      check("t5_in_ready", 32'(in_ready), 32'd1);
      in_data  = 8'hFF;
      in_amt   = 6'd63;
      in_dir   = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      check("t5_busy_before_rst", 32'(busy), 32'd1);
`ifndef MULTI_SHIFT_MOD_REDUCE_EN
      check("t5_steps_before_rst", 32'(steps), 32'd3);
`endif
      rst = 1'b1;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_out_valid", 32'(out_valid), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready), 32'd0);
      check("t5_rst_sh_a", 32'(sh_a), 32'd0);
      check("t5_rst_sh_s", 32'(sh_s), 32'd0);
      check("t5_rst_sh_dir", 32'(sh_dir), 32'd0);
      check("t5_rst_out_data", 32'(out_data), 32'd0);
      check("t5_rst_steps", 32'(steps), 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("t5_release_in_ready", 32'(in_ready), 32'd1);
      request(8'h01, 6'd9, 1'b0, n, s0, s1, s2);
      check("t5_data", 32'(out_data), 32'h02);
`ifdef MULTI_SHIFT_MOD_REDUCE_EN
      check("t5_steps", 32'(steps), 32'd1);
`else
      check("t5_sh_s0", 32'(s0), 32'd7);
      check("t5_sh_s1", 32'(s1), 32'd2);
      check("t5_steps", 32'(steps), 32'd2);
`endif
      step();
      check("t5_in_ready_after", 32'(in_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
